reorder_buffer: RTL

In-order commit buffer for the out-of-order core; it is the writer side of the architectural register file's retire port. Decode allocates an entry per instruction in program order and gets a tag. Execution units later report results by tag. The buffer retires completed head entries one per cycle, in order, by driving `retire_valid`, `retire_reg` and `retire_reg_data` into the architectural register file.

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/reorder_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared core types for the reorder buffer
package reorder_buffer_pkg;

  localparam int ROB_NUM_ENTRIES  = 16;
  localparam int ROB_TAG_W        = $clog2(ROB_NUM_ENTRIES);
  localparam int ROB_NUM_REG_LOG2 = 5;
  localparam int ROB_REG_SIZE     = 32;

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                        valid;
    logic                        done;
    logic                        has_rd;
    logic [ROB_NUM_REG_LOG2-1:0] rd;
    logic [ROB_REG_SIZE-1:0]     data;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order commit buffer driving the register file retire port
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int NUM_ENTRIES      = ROB_NUM_ENTRIES,
  parameter int NUM_ENTRIES_LOG2 = $clog2(NUM_ENTRIES),
  parameter int NUM_REG          = 32,
  parameter int NUM_REG_LOG2     = $clog2(NUM_REG),
  parameter int REG_SIZE         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        alloc_valid,
  input  logic                        alloc_has_rd,
  input  logic [NUM_REG_LOG2-1:0]     alloc_rd,
  output logic                        alloc_ready,
  output logic [NUM_ENTRIES_LOG2-1:0] alloc_tag,
  input  logic                        complete_valid,
  input  logic [NUM_ENTRIES_LOG2-1:0] complete_tag,
  input  logic [REG_SIZE-1:0]         complete_data,
  output logic                        retire_valid,
  output logic [NUM_REG_LOG2-1:0]     retire_reg,
  output logic [REG_SIZE-1:0]         retire_reg_data,
  output logic                        rob_empty
);

  localparam logic [NUM_ENTRIES_LOG2:0] FULL_COUNT = (NUM_ENTRIES_LOG2+1)'(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0]      valid_q, valid_d;
  logic [NUM_ENTRIES-1:0]      done_q, done_d;
  logic [NUM_ENTRIES-1:0]      has_rd_q, has_rd_d;
  logic [NUM_REG_LOG2-1:0]     rd_q   [NUM_ENTRIES];
  logic [NUM_REG_LOG2-1:0]     rd_d   [NUM_ENTRIES];
  logic [REG_SIZE-1:0]         data_q [NUM_ENTRIES];
  logic [REG_SIZE-1:0]         data_d [NUM_ENTRIES];
  logic [NUM_ENTRIES_LOG2-1:0] head_q, head_d;
  logic [NUM_ENTRIES_LOG2-1:0] tail_q, tail_d;
  logic [NUM_ENTRIES_LOG2:0]   count_q, count_d;
  logic                        retire_valid_q, retire_valid_d;
  logic [NUM_REG_LOG2-1:0]     retire_reg_q, retire_reg_d;
  logic [REG_SIZE-1:0]         retire_data_q, retire_data_d;

  logic alloc_fire;
  logic complete_fire;
  logic retire_fire;

  // Handshake qualifiers; no retire-to-alloc bypass, so ready sees registered count only.
  always_comb begin
    alloc_ready   = (count_q != FULL_COUNT);
    alloc_tag     = tail_q;
    rob_empty     = (count_q == '0);
    alloc_fire    = alloc_valid & alloc_ready;
    complete_fire = complete_valid & valid_q[complete_tag] & ~done_q[complete_tag];
    retire_fire   = valid_q[head_q] & done_q[head_q];
  end

  assign retire_valid    = retire_valid_q;
  assign retire_reg      = retire_reg_q;
  assign retire_reg_data = retire_data_q;

  // Next state: flush squashes everything, otherwise complete, retire and allocate in parallel.
  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    has_rd_d       = has_rd_q;
    rd_d           = rd_q;
    data_d         = data_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    retire_valid_d = 1'b0;
    retire_reg_d   = retire_reg_q;
    retire_data_d  = retire_data_q;

    if (flush) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (complete_fire) begin
        done_d[complete_tag] = 1'b1;
        data_d[complete_tag] = complete_data;
      end
      // Retire looks at registered done, so a completion this edge retires next edge at the earliest.
      if (retire_fire) begin
        retire_valid_d  = 1'b1;
        retire_reg_d    = has_rd_q[head_q] ? rd_q[head_q] : '0;
        retire_data_d   = data_q[head_q];
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      // The tail slot is never valid when alloc is ready, so it cannot collide with complete or retire.
      if (alloc_fire) begin
        valid_d[tail_q]  = 1'b1;
        done_d[tail_q]   = 1'b0;
        has_rd_d[tail_q] = alloc_has_rd;
        rd_d[tail_q]     = alloc_rd;
        tail_d           = tail_q + 1'b1;
      end
      if (alloc_fire && !retire_fire) begin
        count_d = count_q + 1'b1;
      end else if (!alloc_fire && retire_fire) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q        <= '0;
      done_q         <= '0;
      has_rd_q       <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      retire_reg_q   <= '0;
      retire_data_q  <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      has_rd_q       <= has_rd_d;
      rd_q           <= rd_d;
      data_q         <= data_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      retire_valid_q <= retire_valid_d;
      retire_reg_q   <= retire_reg_d;
      retire_data_q  <= retire_data_d;
    end
  end

endmodule
